// File: rtl/fsx_vram_arbiter_pkg.sv
// Shared types and constants for the FSX VRAM host-port arbiter.
package fsx_vram_arbiter_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Requester identifiers (also index the per-requester read-data registers)
    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    // Width of the per-frame stall counter
    localparam int STALL_W = 16;

    // Saturating increment so a very long stall reads as 0xFFFF instead of wrapping
    function automatic logic [STALL_W-1:0] stall_inc(input logic [STALL_W-1:0] v);
        return (v == {STALL_W{1'b1}}) ? v : v + STALL_W'(1);
    endfunction

endpackage

// File: rtl/fsx_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that was not served last wins.
module fsx_rr_pick
    import fsx_vram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    // Pick a winner among the active requests
    always_comb begin
        valid = |req;
        gnt   = GNT_A;
        if (req == 2'b11) begin
            gnt = ~last;
        end else if (req[1]) begin
            gnt = GNT_B;
        end
    end

endmodule

// File: rtl/fsx_vram_arbiter.sv
// Arbitrates the VRAM host port between the CPU (A) and the blitter (B).
// New accesses start only while the display is blanked (unless ALLOW_ACTIVE);
// blocked request cycles are counted per frame for software budgeting.
module fsx_vram_arbiter
    import fsx_vram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int ALLOW_ACTIVE = 0
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               blank,
    input  logic               frame_start,
    input  logic               a_req,
    input  logic               a_we,
    input  logic [ADDR_W-1:0]  a_addr,
    input  logic [DATA_W-1:0]  a_wdata,
    output logic               a_ack,
    output logic [DATA_W-1:0]  a_rdata,
    input  logic               b_req,
    input  logic               b_we,
    input  logic [ADDR_W-1:0]  b_addr,
    input  logic [DATA_W-1:0]  b_wdata,
    output logic               b_ack,
    output logic [DATA_W-1:0]  b_rdata,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_q,
    output logic               busy,
    output logic [STALL_W-1:0] stall_last
);

    // Edge count (from ISSUE entry) at which read data is valid on ram_q
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT);

    arb_state_t          state_reg, state_next;
    logic                gnt_reg;
    logic                last_grant_reg;
    logic                op_we_reg;
    logic [2:0]          lat_cnt_reg;
    logic [ADDR_W-1:0]   ram_addr_reg;
    logic                ram_we_reg;
    logic [DATA_W-1:0]   ram_wdata_reg;
    logic [STALL_W-1:0]  stall_cnt_reg;
    logic [STALL_W-1:0]  stall_last_reg;
    logic                frame_d_reg;

    logic                pick_gnt, pick_valid;
    logic                gate_open, grant, stall_now, lat_hit, capture, frame_rise;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    fsx_rr_pick u_pick (
        .req   ({b_req, a_req}),
        .last  (last_grant_reg),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    assign gate_open  = blank | (ALLOW_ACTIVE != 0);
    assign grant      = (state_reg == ST_IDLE) & pick_valid & gate_open;
    assign stall_now  = (state_reg == ST_IDLE) & pick_valid & ~gate_open;
    assign lat_hit    = (lat_cnt_reg == LAT_LAST);
    assign capture    = ((state_reg == ST_ISSUE) | (state_reg == ST_WAIT)) & ~op_we_reg & lat_hit;
    assign frame_rise = frame_start & ~frame_d_reg;

    assign sel_we    = (pick_gnt == GNT_B) ? b_we    : a_we;
    assign sel_addr  = (pick_gnt == GNT_B) ? b_addr  : a_addr;
    assign sel_wdata = (pick_gnt == GNT_B) ? b_wdata : a_wdata;

    // State register
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: writes skip WAIT, reads wait until RD_LAT edges have passed
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (grant) state_next = ST_ISSUE;
            ST_ISSUE: state_next = (op_we_reg || lat_hit) ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (lat_hit) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Grant bookkeeping, RAM command registers and read-latency counter
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            gnt_reg        <= GNT_A;
            last_grant_reg <= GNT_B;
            op_we_reg      <= 1'b0;
            lat_cnt_reg    <= 3'd0;
            ram_addr_reg   <= '0;
            ram_we_reg     <= 1'b0;
            ram_wdata_reg  <= '0;
        end else begin
            ram_we_reg <= 1'b0;
            if (grant) begin
                gnt_reg        <= pick_gnt;
                last_grant_reg <= pick_gnt;
                op_we_reg      <= sel_we;
                ram_we_reg     <= sel_we;
                ram_addr_reg   <= sel_addr;
                ram_wdata_reg  <= sel_wdata;
                lat_cnt_reg    <= 3'd1;
            end else if ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)) begin
                lat_cnt_reg <= lat_cnt_reg + 3'd1;
            end
        end
    end

    // Per-requester read-data holding registers, loaded only by that requester's reads
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            logic [DATA_W-1:0] rdata_reg;

            // Capture ram_q on the final latency edge of a read owned by this requester
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    rdata_reg <= '0;
                end else if (capture && (gnt_reg == 1'(gi))) begin
                    rdata_reg <= ram_q;
                end
            end
        end
    endgenerate

    // Stall counting; a frame_start rising edge publishes and restarts the count
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            stall_cnt_reg  <= '0;
            stall_last_reg <= '0;
            frame_d_reg    <= 1'b0;
        end else begin
            frame_d_reg <= frame_start;
            if (frame_rise) begin
                stall_last_reg <= stall_cnt_reg;
                stall_cnt_reg  <= stall_now ? STALL_W'(1) : '0;
            end else if (stall_now) begin
                stall_cnt_reg <= stall_inc(stall_cnt_reg);
            end
        end
    end

    assign a_ack      = (state_reg == ST_DONE) & (gnt_reg == GNT_A);
    assign b_ack      = (state_reg == ST_DONE) & (gnt_reg == GNT_B);
    assign a_rdata    = g_rdata[0].rdata_reg;
    assign b_rdata    = g_rdata[1].rdata_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_we     = ram_we_reg;
    assign ram_wdata  = ram_wdata_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign stall_last = stall_last_reg;

endmodule

// File: tb/tb_fsx_vram_arbiter.sv
// Bench for fsx_vram_arbiter: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
// Each access pushes its expected ack cycle / read data; a negedge monitor pops on ack.
module tb_fsx_vram_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, blank, frame_start;
    logic           req   [2][2];
    logic           we    [2][2];
    logic [AW-1:0]  addr  [2][2];
    logic [DW-1:0]  wdata [2][2];
    logic           ack   [2][2];
    logic [DW-1:0]  rdata [2][2];
    logic [AW-1:0]  ram_addr  [2];
    logic           ram_we    [2];
    logic [DW-1:0]  ram_wdata [2];
    logic [DW-1:0]  ram_q     [2];
    logic           busy      [2];
    logic [15:0]    stall_last[2];

    fsx_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .ALLOW_ACTIVE(0)) dut0 (
        .vga_clk(clk), .reset(reset), .blank(blank), .frame_start(frame_start),
        .a_req(req[0][0]), .a_we(we[0][0]), .a_addr(addr[0][0]), .a_wdata(wdata[0][0]),
        .a_ack(ack[0][0]), .a_rdata(rdata[0][0]),
        .b_req(req[0][1]), .b_we(we[0][1]), .b_addr(addr[0][1]), .b_wdata(wdata[0][1]),
        .b_ack(ack[0][1]), .b_rdata(rdata[0][1]),
        .ram_addr(ram_addr[0]), .ram_we(ram_we[0]), .ram_wdata(ram_wdata[0]), .ram_q(ram_q[0]),
        .busy(busy[0]), .stall_last(stall_last[0])
    );

    fsx_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .ALLOW_ACTIVE(0)) dut1 (
        .vga_clk(clk), .reset(reset), .blank(blank), .frame_start(frame_start),
        .a_req(req[1][0]), .a_we(we[1][0]), .a_addr(addr[1][0]), .a_wdata(wdata[1][0]),
        .a_ack(ack[1][0]), .a_rdata(rdata[1][0]),
        .b_req(req[1][1]), .b_we(we[1][1]), .b_addr(addr[1][1]), .b_wdata(wdata[1][1]),
        .b_ack(ack[1][1]), .b_rdata(rdata[1][1]),
        .ram_addr(ram_addr[1]), .ram_we(ram_we[1]), .ram_wdata(ram_wdata[1]), .ram_q(ram_q[1]),
        .busy(busy[1]), .stall_last(stall_last[1])
    );

    // RAM models: data is captured by the DUT RD_LAT edges after ram_addr is set
    logic [DW-1:0] mem0 [16384];
    logic [DW-1:0] mem1 [16384];
    logic [DW-1:0] q1a, q1b;
    always @(posedge clk) if (ram_we[0]) mem0[ram_addr[0]] <= ram_wdata[0];
    assign ram_q[0] = mem0[ram_addr[0]];
    always @(posedge clk) begin
        if (ram_we[1]) mem1[ram_addr[1]] <= ram_wdata[1];
        q1a <= mem1[ram_addr[1]];
        q1b <= q1a;
    end
    assign ram_q[1] = q1b;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int            inst;
        int            port;
        bit            rd;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } we_t;
    we_t we_log[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: pop expectation on each ack, log every instance-0 RAM write cycle
    always @(negedge clk) begin
        int idx;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (ack[i][p]) begin
                        idx = -1;
                        for (int n = 0; n < sb.size(); n++)
                            if (idx < 0 && sb[n].inst == i && sb[n].port == p) idx = n;
                        if (idx < 0) begin
                            n_checks++;
                            $display("FAIL unexpected_ack: inst %0d port %0d acked at cycle %0d, none required", i, p, cyc);
                        end else begin
                            chk($sformatf("ack_cycle i%0d p%0d", i, p), cyc, sb[idx].cyc);
                            if (sb[idx].rd) chk($sformatf("rdata i%0d p%0d", i, p), rdata[i][p], sb[idx].data);
                            chk($sformatf("ack_overlap i%0d", i), {31'd0, ack[i][1-p]}, 32'd0);
                            sb.delete(idx);
                        end
                    end
                end
            end
            if (ram_we[0]) we_log.push_back('{cyc, ram_addr[0], ram_wdata[0]});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request; lat = ack cycle minus current cycle (hand-computed)
    task automatic issue(input int i, input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int lat, input bit push);
        we[i][p]    = w;
        addr[i][p]  = a;
        wdata[i][p] = d;
        req[i][p]   = 1'b1;
        if (push) sb.push_back('{i, p, !w, d, cyc + lat});
    endtask

    // Wait (bounded) for the ack, then drop req the cycle after it
    task automatic wait_ack(input int i, input int p);
        bit got = 0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            got = ack[i][p];
        end
        n_checks++;
        if (got) n_pass++;
        else $display("FAIL ack_timeout: inst %0d port %0d got no ack, ack required", i, p);
        @(posedge clk);
        #1;
        req[i][p] = 1'b0;
    endtask

    task automatic frame_pulse(input int len);
        frame_start = 1'b1;
        tick(len);
        frame_start = 1'b0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1; blank = 1'b1; frame_start = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++) begin
                req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0;
            end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy0", busy[0], 0);
        chk("rst_busy1", busy[1], 0);
        chk("rst_ram_we0", ram_we[0], 0);
        chk("rst_ram_addr0", ram_addr[0], 0);
        chk("rst_ram_wdata0", ram_wdata[0], 0);
        chk("rst_a_ack0", ack[0][0], 0);
        chk("rst_a_rdata0", rdata[0][0], 0);
        chk("rst_stall_last0", stall_last[0], 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(2);

        // T1: A write 0x0123 <- 0xDEADBEEF
        we_log.delete();
        k = cyc;
        issue(0, 0, 1'b1, 14'h0123, 32'hDEADBEEF, 2, 1);
        wait_ack(0, 0);
        chk("t1_we_count", we_log.size(), 1);
        if (we_log.size() == 1) begin
            chk("t1_we_cycle", we_log[0].cyc, k + 1);
            chk("t1_we_addr", we_log[0].addr, 32'h0123);
            chk("t1_we_data", we_log[0].data, 32'hDEADBEEF);
        end

        // T2: reads on RD_LAT=1, plus B write/read and A rdata hold
        we_log.delete();
        issue(0, 0, 1'b0, 14'h0123, 32'hDEADBEEF, 2, 1);
        wait_ack(0, 0);
        chk("t2_read_no_we", we_log.size(), 0);
        issue(0, 1, 1'b1, 14'h0456, 32'h12345678, 2, 1);
        wait_ack(0, 1);
        issue(0, 1, 1'b0, 14'h0456, 32'h12345678, 2, 1);
        wait_ack(0, 1);
        chk("t2_a_rdata_hold", rdata[0][0], 32'hDEADBEEF);
        // T2 with RD_LAT=3
        issue(1, 0, 1'b1, 14'h0123, 32'hDEADBEEF, 2, 1);
        wait_ack(1, 0);
        issue(1, 0, 1'b0, 14'h0123, 32'hDEADBEEF, 4, 1);
        wait_ack(1, 0);

        // T3: continuous A and B; A wins first (last grant was B), then alternation
        fork
            begin
                for (int j = 0; j < 3; j++) begin
                    issue(0, 0, 1'b1, 14'(16 + j), 32'hA000 + j, (j == 0) ? 2 : 5, 1);
                    wait_ack(0, 0);
                end
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    issue(0, 1, 1'b1, 14'(32 + j), 32'hB000 + j, 5, 1);
                    wait_ack(0, 1);
                end
            end
        join

        // T4: B held 100 cycles in active display, then blank
        frame_pulse(1);
        chk("t4_stall_last_pre", stall_last[0], 0);
        we_log.delete();
        blank = 1'b0;
        k = cyc;
        issue(0, 1, 1'b1, 14'h0300, 32'hCAFE0300, 102, 1);
        tick(100);
        blank = 1'b1;
        wait_ack(0, 1);
        chk("t4_we_count", we_log.size(), 1);
        if (we_log.size() == 1) chk("t4_we_cycle", we_log[0].cyc, k + 101);
        frame_pulse(3);
        chk("t4_stall_last", stall_last[0], 100);

        // T5: blank falls while A's write is in ISSUE; B must wait for blank
        we_log.delete();
        k = cyc;
        issue(0, 0, 1'b1, 14'h0400, 32'h00000400, 2, 1);
        tick(1);
        blank = 1'b0;
        issue(0, 1, 1'b1, 14'h0401, 32'h00000401, 11, 1);
        wait_ack(0, 0);
        tick(7);
        blank = 1'b1;
        wait_ack(0, 1);
        chk("t5_we_count", we_log.size(), 2);
        if (we_log.size() == 2) chk("t5_b_we_cycle", we_log[1].cyc, k + 11);
        frame_pulse(1);
        chk("t5_stall_last", stall_last[0], 7);

        // T6: reset during WAIT of an RD_LAT=3 read
        issue(1, 0, 1'b0, 14'h0123, 32'h0, 0, 0);
        tick(2);
        chk("t6_busy_pre", busy[1], 1);
        reset = 1'b1;
        req[1][0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_busy", busy[1], 0);
        chk("t6_ram_we", ram_we[1], 0);
        chk("t6_ack", ack[1][0], 0);
        chk("t6_stall_last0", stall_last[0], 0);
        reset = 1'b0;
        tick(2);
        issue(1, 0, 1'b0, 14'h0123, 32'hDEADBEEF, 4, 1);
        wait_ack(1, 0);
        // After reset A wins the first tie
        issue(0, 0, 1'b1, 14'h0500, 32'h500, 2, 1);
        issue(0, 1, 1'b1, 14'h0501, 32'h501, 5, 1);
        fork
            wait_ack(0, 0);
            wait_ack(0, 1);
        join
        tick(3);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
